// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types for the message padder and compression core.
// Holds the padder state encoding, block geometry and the initial hash values.
package sha256_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      PAD    = 2'd1,
      LENBLK = 2'd2,
      EMIT   = 2'd3
   } pad_state_e;

   localparam int unsigned BLOCK_BYTES = 64;
   localparam int unsigned LEN_OFFSET  = 56;
   localparam logic [7:0]  PAD_BYTE    = 8'h80;

   localparam logic [31:0] H0 = 32'h6a09e667;
   localparam logic [31:0] H1 = 32'hbb67ae85;
   localparam logic [31:0] H2 = 32'h3c6ef372;
   localparam logic [31:0] H3 = 32'ha54ff53a;
   localparam logic [31:0] H4 = 32'h510e527f;
   localparam logic [31:0] H5 = 32'h9b05688c;
   localparam logic [31:0] H6 = 32'h1f83d9ab;
   localparam logic [31:0] H7 = 32'h5be0cd19;

   // Big-endian length byte for block lanes 56..63; lane 56 carries the MSB.
   function automatic logic [7:0] len_byte(input logic [63:0] len, input int unsigned lane);
      logic [2:0] k;
      k = 3'(lane);
      return len[(7 - int'(k)) * 8 +: 8];
   endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_padder
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   input  logic         in_empty,
   output logic [511:0] block_out,
   output logic         block_valid,
   input  logic         block_ready,
   output logic         block_first,
   output logic         block_last
);

   pad_state_e  state_q, state_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [63:0] len_q, len_d;
   logic        first_pend_q, first_pend_d;
   logic        len_pend_q, len_pend_d;
   logic        end_pend_q, end_pend_d;
   logic        final_q, final_d;

   logic [7:0]  blk_q [BLOCK_BYTES];
   logic        lane_we [BLOCK_BYTES];
   logic [7:0]  lane_wdata [BLOCK_BYTES];

   logic        byte_xfer;
   logic        empty_xfer;
   logic        len_fits;

   assign in_ready   = (state_q == FILL);
   assign byte_xfer  = in_valid && in_ready && !in_empty;
   assign empty_xfer = in_valid && in_ready && in_empty;
   assign len_fits   = (ptr_q < 6'(LEN_OFFSET));

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      len_d        = len_q;
      first_pend_d = first_pend_q;
      len_pend_d   = len_pend_q;
      end_pend_d   = end_pend_q;
      final_d      = final_q;

      case (state_q)
         FILL: begin
            if (byte_xfer) begin
               ptr_d = ptr_q + 6'd1;
               len_d = len_q + 64'd8;
               if (ptr_q == 6'd63) begin
                  // Buffer full: ship it as a data block, pad afterwards if this ended the message.
                  state_d    = EMIT;
                  final_d    = 1'b0;
                  end_pend_d = in_last;
               end else if (in_last) begin
                  state_d = PAD;
               end
            end else if (empty_xfer) begin
               state_d = PAD;
            end
         end
         PAD: begin
            state_d = EMIT;
            if (len_fits) begin
               final_d = 1'b1;
            end else begin
               final_d    = 1'b0;
               len_pend_d = 1'b1;
            end
         end
         LENBLK: begin
            state_d = EMIT;
            final_d = 1'b1;
         end
         EMIT: begin
            if (block_ready) begin
               first_pend_d = 1'b0;
               if (final_q) begin
                  state_d      = FILL;
                  ptr_d        = 6'd0;
                  len_d        = 64'd0;
                  first_pend_d = 1'b1;
               end else if (len_pend_q) begin
                  state_d    = LENBLK;
                  len_pend_d = 1'b0;
               end else if (end_pend_q) begin
                  state_d    = PAD;
                  end_pend_d = 1'b0;
                  ptr_d      = 6'd0;
               end else begin
                  state_d = FILL;
                  ptr_d   = 6'd0;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Per-lane write enables; PAD and LENBLK rewrite every byte past the pointer.
   always_comb begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         lane_we[i]    = 1'b0;
         lane_wdata[i] = 8'h00;
         case (state_q)
            FILL: begin
               if (byte_xfer && (ptr_q == 6'(i))) begin
                  lane_we[i]    = 1'b1;
                  lane_wdata[i] = in_data;
               end
            end
            PAD: begin
               if (6'(i) == ptr_q) begin
                  lane_we[i]    = 1'b1;
                  lane_wdata[i] = PAD_BYTE;
               end else if (6'(i) > ptr_q) begin
                  lane_we[i] = 1'b1;
                  if ((i >= LEN_OFFSET) && len_fits) begin
                     lane_wdata[i] = len_byte(len_q, i);
                  end
               end
            end
            LENBLK: begin
               lane_we[i] = 1'b1;
               if (i >= LEN_OFFSET) begin
                  lane_wdata[i] = len_byte(len_q, i);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FILL;
         ptr_q        <= 6'd0;
         len_q        <= 64'd0;
         first_pend_q <= 1'b1;
         len_pend_q   <= 1'b0;
         end_pend_q   <= 1'b0;
         final_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         len_q        <= len_d;
         first_pend_q <= first_pend_d;
         len_pend_q   <= len_pend_d;
         end_pend_q   <= end_pend_d;
         final_q      <= final_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BLOCK_BYTES; i++) begin
            blk_q[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (lane_we[i]) begin
               blk_q[i] <= lane_wdata[i];
            end
         end
      end
   end

   assign block_valid = (state_q == EMIT);
   assign block_first = block_valid && first_pend_q;
   assign block_last  = block_valid && final_q;

   for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_lane
      assign block_out[511 - 8*g -: 8] = blk_q[g];
   end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: table-driven messages plus random ones,
// each compared block-by-block against a FIPS 180-4 padding model.
module tb_sha256_padder;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         in_empty;
   logic [511:0] block_out;
   logic         block_valid;
   logic         block_ready;
   logic         block_first;
   logic         block_last;

   sha256_padder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_empty    (in_empty),
      .block_out   (block_out),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .block_first (block_first),
      .block_last  (block_last)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          n;
      bit          empty_end;
      int          exp_blocks;
      logic [31:0] exp_w15;
   } vec_t;

   logic [7:0]   msg[$];
   logic [511:0] exp_blk[$];
   bit           exp_first[$];
   bit           exp_last[$];
   int           got_blocks;
   logic [31:0]  last_w15;
   logic [511:0] first_blk;

   localparam logic [511:0] AbcBlock   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EmptyBlock = {32'h80000000, 480'h0};

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Standard padding on the whole message, then split into 64-byte blocks.
   task automatic build_model();
      logic [7:0]   p[$];
      logic [63:0]  bitlen;
      logic [511:0] b;
      int           nb;
      p = msg;
      bitlen = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
      nb = p.size() / 64;
      for (int j = 0; j < nb; j++) begin
         for (int i = 0; i < 64; i++) b[511 - 8*i -: 8] = p[64*j + i];
         exp_blk.push_back(b);
         exp_first.push_back(j == 0);
         exp_last.push_back(j == nb - 1);
      end
   endtask

   task automatic wait_ready();
      int c = 0;
      while (!in_ready && c < 2000) begin
         @(posedge clk); #1;
         c++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL in_ready_timeout: got 0, expected 1");
      end
   endtask

   task automatic send_msg(input bit empty_end);
      for (int i = 0; i < msg.size(); i++) begin
         in_valid = 1'b1;
         in_data  = msg[i];
         in_empty = 1'b0;
         in_last  = !empty_end && (i == msg.size() - 1);
         wait_ready();
         @(posedge clk); #1;
      end
      if (empty_end) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_empty = 1'b1;
         in_last  = 1'b0;
         wait_ready();
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_empty = 1'b0;
   endtask

   task automatic collect(input int stall_lo, input int stall_hi);
      logic [511:0] cap_out;
      logic [2:0]   cap_flags;
      int           c;
      int           stall;
      got_blocks = 0;
      for (int blk = 0; blk < 10; blk++) begin
         c = 0;
         while (!block_valid && c < 500) begin
            @(posedge clk); #1;
            c++;
         end
         if (!block_valid) begin
            check("block_valid_timeout", 0, 1);
            return;
         end
         cap_out   = block_out;
         cap_flags = {block_valid, block_first, block_last};
         stall = $urandom_range(stall_hi, stall_lo);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("hold_out", block_out, cap_out);
            check("hold_flags", {block_valid, block_first, block_last}, cap_flags);
            check("stall_in_ready", in_ready, 0);
         end
         if (exp_blk.size() == 0) begin
            check("extra_block", 1, 0);
         end else begin
            check("blk_data", cap_out, exp_blk.pop_front());
            check("blk_first", cap_flags[1], exp_first.pop_front());
            check("blk_last", cap_flags[0], exp_last.pop_front());
         end
         if (got_blocks == 0) first_blk = cap_out;
         got_blocks++;
         last_w15 = cap_out[31:0];
         block_ready = 1'b1;
         @(posedge clk); #1;
         block_ready = 1'b0;
         if (cap_flags[0]) break;
      end
   endtask

   task automatic run_msg(input int n, input bit empty_end, input bit use_abc,
                          input int stall_lo, input int stall_hi);
      int ec;
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(use_abc ? 8'(8'h61 + i) : 8'($urandom));
      build_model();
      ec = exp_blk.size();
      fork
         send_msg(empty_end);
         collect(stall_lo, stall_hi);
      join
      check("block_count", got_blocks, ec);
      check("model_drained", exp_blk.size(), 0);
      check("idle_in_ready", in_ready, 1);
      exp_blk.delete();
      exp_first.delete();
      exp_last.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[8];
      int   seen;
      vt[0] = '{3,   1'b0, 1, 32'h00000018};
      vt[1] = '{0,   1'b1, 1, 32'h00000000};
      vt[2] = '{55,  1'b0, 1, 32'h000001B8};
      vt[3] = '{56,  1'b0, 2, 32'h000001C0};
      vt[4] = '{64,  1'b0, 2, 32'h00000200};
      vt[5] = '{64,  1'b1, 2, 32'h00000200};
      vt[6] = '{63,  1'b0, 2, 32'h000001F8};
      vt[7] = '{120, 1'b1, 3, 32'h000003C0};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
      block_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_valid", block_valid, 0);
      check("rst_first", block_first, 0);
      check("rst_last", block_last, 0);
      check("rst_block_out", block_out, 0);

      for (int v = 0; v < 8; v++) begin
         run_msg(vt[v].n, vt[v].empty_end, (v == 0), 0, 2);
         check("tbl_nblocks", got_blocks, vt[v].exp_blocks);
         check("tbl_len_word", last_w15, vt[v].exp_w15);
         if (v == 0) check("abc_block", first_blk, AbcBlock);
         if (v == 1) check("empty_block", first_blk, EmptyBlock);
      end

      // Long downstream stall, then an immediate follow-on message.
      run_msg(70, 1'b0, 1'b0, 10, 10);
      run_msg(5, 1'b0, 1'b0, 0, 0);
      check("b2b_len_word", last_w15, 32'h00000028);

      // Reset part-way through a message: nothing may come out afterwards.
      for (int i = 0; i < 30; i++) begin
         in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; in_empty = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_block_out", block_out, 0);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (block_valid) seen++;
      end
      check("midrst_no_block", seen, 0);
      check("midrst_in_ready", in_ready, 1);
      run_msg(3, 1'b0, 1'b1, 0, 1);
      check("midrst_abc_block", first_blk, AbcBlock);

      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(150, 0);
         run_msg(n, (n == 0) ? 1'b1 : 1'($urandom_range(1, 0)), 1'b0, 0, 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream message-formatting stage for the SHA-256 compression core. Accepts an arbitrary-length byte stream and appends the FIPS 180-4 padding: 0x80, zero fill, and the 64-bit big-endian bit length. Emits complete 512-bit blocks with first/last-of-message flags over a valid/ready handshake. A sequencer maps `block_first` to the core's `first_run` and `block_valid` to its `start`.

## Interface
- No parameters; constants come from the shared package.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  byte or end-marker present.
- `in_ready`  out  1  padder can accept; high only in FILL.
- `in_data`  in  8  message byte.
- `in_last`  in  1  `in_data` is the final byte of the message.
- `in_empty`  in  1  end-of-message with no byte; `in_data` is ignored. Used for zero-length messages or an end marker after a non-`in_last` byte.
- `block_out`  out  512  block; byte i of the block at [511-8i -: 8].
- `block_valid`  out  1  `block_out` and flags valid.
- `block_ready`  in  1  downstream accepts.
- `block_first`  out  1  first block of its message.
- `block_last`  out  1  final (length-carrying) block of its message.

## Operation
- Internal state: 64-byte buffer, 6-bit byte pointer `ptr`, 64-bit bit counter `len`, flags `first_pend` and `len_pend`.
- **FILL**
  - Byte transfer (`in_valid && in_ready && !in_empty`): write `buf[ptr]`, then `ptr+1` and `len+8` (`len` wraps mod 2^64).
  - If `in_last` and `ptr` was <63 → PAD.
  - If `ptr` was 63 → EMIT. If `in_last` was also set, record `end_pend`; after the handshake, go to PAD with `ptr=0`.
  - `in_empty` transfer → PAD; buffer and `len` are unchanged.
- **PAD** (1 cycle)
  - At pointer p: `buf[p]=0x80`, bytes p+1..63 = 0.
  - If p≤55: bytes 56..63 = `len`, block is final.
  - Otherwise: `len_pend=1`, block is not final.
  - Next state → EMIT.
- **LENBLK** (1 cycle): bytes 0..55 = 0, bytes 56..63 = `len`, block is final; next state → EMIT.
- **EMIT**
  - `block_valid=1`; `block_first=first_pend`; `block_last` = final.
  - Outputs are held stable until `block_ready`.
  - On handshake, `first_pend=0`, then:
    - if final → FILL, with `ptr=0`, `len=0`, `first_pend=1`;
    - else if `len_pend` → LENBLK, clearing `len_pend`;
    - else if `end_pend` → PAD;
    - else → FILL, with `ptr=0`.
- `in_ready=0` in PAD, LENBLK and EMIT; upstream is back-pressured while a block is pending.
- `block_out` reflects the buffer directly; stale bytes are never visible because PAD/LENBLK overwrite every unfilled byte.

## Timing
- Reset values:
  - state FILL, so `in_ready=1`;
  - `block_valid=0`, `block_first=0`, `block_last=0`, `block_out=0`;
  - `ptr=0`, `len=0`, `first_pend=1`, pending flags 0.
- Reset mid-operation discards the partial block and `len`; no block is emitted afterwards.
- Latency:
  - last byte accepted at cycle N → PAD at N+1 → `block_valid` at N+2;
  - LENBLK adds 1 cycle after the previous handshake.
- A full data block (64th byte at N) → `block_valid` at N+1.
- Handshake completes on a cycle with `block_valid && block_ready`; at most one block is transferred per cycle.
- `block_valid` does not depend combinationally on `block_ready`.
- Throughput: 65 cycles per full data block with zero downstream stall.

## Structure
- Shared package `sha256_pkg`:
  - state enum FILL/PAD/LENBLK/EMIT;
  - `BLOCK_BYTES=64`, `LEN_OFFSET=56`, `PAD_BYTE=8'h80`;
  - the H0–H7 IV constants, shared with the core.
- Single module; byte-lane write enables are generated with a for-loop over 64 lanes. No sub-module is needed.

## Test plan
- "abc" (0x61,0x62,0x63, `in_last` on 0x63) → one block, word0=0x61626380, words1–14=0, word15=0x00000018, first=last=1.
- `in_empty` only → one block, word0=0x80000000, all else 0, first=last=1.
- 55 bytes → single block, byte55=0x80, length 0x1B8. 56 bytes → two blocks:
  - block 1: byte56=0x80 then zeros, first=1, last=0;
  - block 2: all-zero except word15=0x000001C0, first=0, last=1.
- 64 bytes with `in_last` on byte 63 → data block (first=1, last=0), then block with byte0=0x80 and length 0x200 (last=1).
- `block_ready` held low 10 cycles → `block_out`/flags stable and `in_ready=0` throughout; then back-to-back messages → second message's first block has `block_first=1` and restarts the length.
- `rst` asserted after 30 bytes → no block emitted; next "abc" produces the exact block from the first scenario.
